wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//  Write-back arbiter that drives the register file's single write port (WB_RegWrite/
//  WB_Write_Register/WB_Write_Data) from two writers: the in-order pipeline WB stage and
//  long-latency units (mul/div) over a valid/ready handshake. Long-latency results are
//  buffered in a FIFO and drained in idle write slots. Query ports report registers with
//  queued writes so the hazard unit can stall readers.
// PARAMETERS
//  DEPTH      4   FIFO entries for long-latency results (power of 2, >=2)
//  CNT_W      3   width of fifo_count; holds 0..DEPTH
//  STARVE_MAX 8   cycles a non-empty FIFO head may wait before a forced drain (guard only)
// PORTS
//  sysclk            in   1   system clock, all logic on rising edge
//  reset_n           in   1   synchronous reset, active-low
//  pipe_we           in   1   pipeline WB stage requests a write this cycle
//  pipe_rd           in   5   pipeline destination register
//  pipe_wd           in   32  pipeline write data
//  lx_valid          in   1   long-latency result valid
//  lx_ready          out  1   arbiter accepts long-latency result this cycle
//  lx_rd             in   5   long-latency destination register
//  lx_wd             in   32  long-latency write data
//  pipe_stall        out  1   pipeline must hold WB stage (pipe_we ignored while high)
//  q_reg1, q_reg2    in   5   registers queried for pending writes
//  q_pending1/2      out  1   queried register has a queued FIFO write
//  fifo_count        out  CNT_W  entries currently queued
//  WB_RegWrite       out  1   register file write enable
//  WB_Write_Register out  5   register file write address
//  WB_Write_Data     out  32  register file write data
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): WB_RegWrite=0, WB_Write_Register=0, WB_Write_Data=0,
//    fifo_count=0, pipe_stall=0, starve counter=0, FIFO entries discarded. While reset_n=0,
//    lx_ready=0. Reset mid-operation drops queued and in-flight writes; no partial write.
//  - lx_ready = reset_n && (fifo_count < DEPTH); uses pre-pop count (full + same-cycle pop
//    is still not ready). Push on lx_valid && lx_ready. lx_rd==0: handshake completes,
//    nothing queued.
//  - Selection each cycle, priority order:
//    1. pipe_stall=1 and FIFO non-empty -> pop head.
//    2. pipe_we=1, pipe_rd!=0, pipe_stall=0 -> pipeline write.
//    3. FIFO non-empty -> pop head.
//    4. none.
//    pipe_we with pipe_rd==0 is a legal no-op and leaves the slot free for the FIFO.
//  - Outputs registered: selected write appears on WB_* at the next edge for exactly one
//    cycle. WB_RegWrite=0 when nothing selected; address/data hold last value.
//    Latency: pipeline write 1 cycle; lx accept into empty FIFO with idle pipeline ->
//    WB_RegWrite 2 cycles after accept edge.
//  - FIFO order strictly preserved; push and pop in the same cycle are allowed;
//    pointers wrap modulo DEPTH.
//  - q_pendingN = 1 iff q_regN != 0 and it matches lx_rd of any occupied FIFO entry;
//    combinational from state. The entry currently on WB_* is not pending (the register
//    file forwards it).
//  - fifo_count: pops are counted at the same edge as the WB_* update.
// CONFIGURATION
//  WB_ARB_STARVE_GUARD_EN defined:
//    - Counter increments each cycle the FIFO is non-empty and no pop occurs; clears on
//      pop or empty.
//    - When the counter reaches STARVE_MAX-1, pipe_stall is set at that edge and held one
//      cycle; the head is popped in that cycle.
//  Not defined:
//    - pipe_stall tied 0, no counter; the pipeline always wins and FIFO drains only in
//      idle slots.
// TESTING
//  1. Reset: hold reset_n=0 2 cycles with lx_valid=1 -> lx_ready=0, WB_RegWrite=0,
//     fifo_count=0, nothing queued.
//  2. pipe_we=1, rd=5, wd=0xDEADBEEF for 1 cycle -> next cycle WB_RegWrite=1, reg=5,
//     data=0xDEADBEEF; following cycle WB_RegWrite=0.
//  3. Same cycle pipe_we(rd=3, 0x11) and lx push(rd=7, 0x22) -> cycle+1 writes r3,
//     cycle+2 writes r7; q_pending for r7 high only during the FIFO-held cycle.
//  4. DEPTH+1 back-to-back lx pushes with pipe_we=1 (rd=1) every cycle, guard off ->
//     lx_ready drops at count=4; FIFO drains in order once pipe_we=0.
//  5. Guard on, STARVE_MAX=8, one queued entry, pipe_we=1 continuously -> pipe_stall
//     high 1 cycle; head written the next cycle; the pipe write in the stall cycle is
//     ignored.
//  6. lx push rd=0 and pipe_we rd=0 -> handshake completes, fifo_count stays 0,
//     no WB_RegWrite.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter - register-file write-port arbiter between the WB stage and a long-latency result FIFO.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 8
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_rd,
    input  logic [31:0]      pipe_wd,
    input  logic             lx_valid,
    output logic             lx_ready,
    input  logic [4:0]       lx_rd,
    input  logic [31:0]      lx_wd,
    output logic             pipe_stall,
    input  logic [4:0]       q_reg1,
    input  logic [4:0]       q_reg2,
    output logic             q_pending1,
    output logic             q_pending2,
    output logic [CNT_W-1:0] fifo_count,
    output logic             WB_RegWrite,
    output logic [4:0]       WB_Write_Register,
    output logic [31:0]      WB_Write_Data
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (1 << CNT_W) <= DEPTH || STARVE_MAX < 2) begin : g_bad_param
        $error("wb_write_arbiter: illegal parameter combination");
    end

    logic [4:0]       mem_rd_q [DEPTH];
    logic [4:0]       mem_rd_d [DEPTH];
    logic [31:0]      mem_wd_q [DEPTH];
    logic [31:0]      mem_wd_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_wd_q, wb_wd_d;
    logic             stall_w;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             pipe_sel;

    assign fifo_empty = (count_q == '0);
    assign lx_ready   = reset_n && (count_q < CNT_W'(DEPTH));
    // A zero destination completes the handshake but is never queued.
    assign push       = lx_valid && lx_ready && (lx_rd != 5'd0);

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int ST_W = $clog2(STARVE_MAX + 1);

    logic [ST_W-1:0] starve_q, starve_d;
    logic            pipe_stall_q, pipe_stall_d;

    always_comb begin
        starve_d     = starve_q;
        pipe_stall_d = 1'b0;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + ST_W'(1);
        end
        pipe_stall_d = (starve_d == ST_W'(STARVE_MAX - 1));
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            starve_q     <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    assign stall_w = pipe_stall_q;
`else
    assign stall_w = 1'b0;
`endif

    assign pipe_stall = stall_w;

    always_comb begin
        pop      = 1'b0;
        pipe_sel = 1'b0;
        if (stall_w && !fifo_empty) begin
            pop = 1'b1;
        end else if (pipe_we && (pipe_rd != 5'd0) && !stall_w) begin
            pipe_sel = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_rd_d[i] = mem_rd_q[i];
            mem_wd_d[i] = mem_wd_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_rd_d[wr_ptr_q] = lx_rd;
            mem_wd_d[wr_ptr_q] = lx_wd;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Address and data hold their last value when no write is issued.
    always_comb begin
        wb_we_d = pop || pipe_sel;
        wb_rd_d = wb_rd_q;
        wb_wd_d = wb_wd_q;
        if (pipe_sel) begin
            wb_rd_d = pipe_rd;
            wb_wd_d = pipe_wd;
        end else if (pop) begin
            wb_rd_d = mem_rd_q[rd_ptr_q];
            wb_wd_d = mem_wd_q[rd_ptr_q];
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_rd_q  <= 5'd0;
            wb_wd_q  <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wb_we_q  <= wb_we_d;
            wb_rd_q  <= wb_rd_d;
            wb_wd_q  <= wb_wd_d;
        end
    end

    always_ff @(posedge sysclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_rd_q[i] <= mem_rd_d[i];
            mem_wd_q[i] <= mem_wd_d[i];
        end
    end

    // An entry is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] off;
        q_pending1 = 1'b0;
        q_pending2 = 1'b0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(off) < count_q) begin
                if (q_reg1 != 5'd0 && mem_rd_q[i] == q_reg1) q_pending1 = 1'b1;
                if (q_reg2 != 5'd0 && mem_rd_q[i] == q_reg2) q_pending2 = 1'b1;
            end
        end
    end

    assign fifo_count        = count_q;
    assign WB_RegWrite       = wb_we_q;
    assign WB_Write_Register = wb_rd_q;
    assign WB_Write_Data     = wb_wd_q;

endmodule
